// File: rtl/osc_wake_ctl.sv
// Oscillator stop/wake controller: crystal pad enable, stabilisation count, and joypad wake request.
// Optional WAKE_DEBOUNCE_EN adds a 4-cycle debounce on the synchronised wake request.
module osc_wake_ctl #(
  parameter int          CNT_W      = 16,
  parameter int unsigned STAB_COUNT = 16'hFFFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       OSC_ENA,
  input  logic       CLK_ENA,
  input  logic [3:0] WAKE_N,
  output logic       XTAL_EN,
  output logic       OSC_STABLE,
  output logic       WAKE,
  output logic       CLK_GATE,
  output logic       STOPPED
);

  typedef enum logic [1:0] {S_WARMUP, S_RUN, S_STOPPED} state_t;

  // Exit WARMUP one count early so the counter never reaches STAB_COUNT.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STAB_COUNT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       sync1, wsync;
  logic             wreq, wake_set;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '1;
      wsync <= '1;
    end else begin
      sync1 <= WAKE_N;
      wsync <= sync1;
    end
  end

  assign wreq = ~&wsync;

`ifdef WAKE_DEBOUNCE_EN
  logic [1:0] deb, deb_nxt;

  always_comb begin
    deb_nxt = '0;
    if (wreq) deb_nxt = (deb == 2'd3) ? deb : deb + 2'd1;
  end

  // Only counts while sitting in STOPPED; any gap or exit starts over.
  always_ff @(posedge CLK) begin
    if (RESET || state != S_STOPPED || OSC_ENA) deb <= '0;
    else                                        deb <= deb_nxt;
  end

  assign wake_set = wreq & (deb == 2'd3);
`else
  assign wake_set = wreq;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_WARMUP;
      cnt        <= '0;
      XTAL_EN    <= 1'b1;
      OSC_STABLE <= 1'b0;
      WAKE       <= 1'b0;
      STOPPED    <= 1'b0;
    end else begin
      case (state)
        S_WARMUP: begin
          if (!OSC_ENA) begin
            state      <= S_STOPPED;
            XTAL_EN    <= 1'b0;
            OSC_STABLE <= 1'b0;
            STOPPED    <= 1'b1;
            WAKE       <= 1'b0;
          end else if (cnt == TERM) begin
            state      <= S_RUN;
            OSC_STABLE <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!OSC_ENA) begin
            state      <= S_STOPPED;
            XTAL_EN    <= 1'b0;
            OSC_STABLE <= 1'b0;
            STOPPED    <= 1'b1;
            WAKE       <= 1'b0;
          end
        end
        S_STOPPED: begin
          if (OSC_ENA) begin
            state   <= S_WARMUP;
            cnt     <= '0;
            XTAL_EN <= 1'b1;
            STOPPED <= 1'b0;
            WAKE    <= 1'b0;
          end else begin
            WAKE <= wake_set;
          end
        end
        default: begin
          state      <= S_WARMUP;
          cnt        <= '0;
          XTAL_EN    <= 1'b1;
          OSC_STABLE <= 1'b0;
          STOPPED    <= 1'b0;
          WAKE       <= 1'b0;
        end
      endcase
    end
  end

  assign CLK_GATE = OSC_STABLE & CLK_ENA;

endmodule

// File: tb/tb_osc_wake_ctl.sv
// Scoreboard bench for osc_wake_ctl with STAB_COUNT=4, CNT_W=4.
// Output vector order: {XTAL_EN, OSC_STABLE, WAKE, CLK_GATE, STOPPED}.
module tb_osc_wake_ctl;

  logic       CLK = 1'b0;
  logic       RESET, OSC_ENA, CLK_ENA;
  logic [3:0] WAKE_N;
  logic       XTAL_EN, OSC_STABLE, WAKE, CLK_GATE, STOPPED;

  osc_wake_ctl #(.CNT_W(4), .STAB_COUNT(4)) dut (
    .CLK(CLK), .RESET(RESET), .OSC_ENA(OSC_ENA), .CLK_ENA(CLK_ENA), .WAKE_N(WAKE_N),
    .XTAL_EN(XTAL_EN), .OSC_STABLE(OSC_STABLE), .WAKE(WAKE), .CLK_GATE(CLK_GATE),
    .STOPPED(STOPPED)
  );

  always #5 CLK = ~CLK;

  wire [4:0] obs = {XTAL_EN, OSC_STABLE, WAKE, CLK_GATE, STOPPED};

  localparam logic [4:0] O_W  = 5'b10000;  // WARMUP
  localparam logic [4:0] O_R  = 5'b11010;  // RUN, CLK_ENA=1
  localparam logic [4:0] O_RG = 5'b11000;  // RUN, CLK_ENA=0
  localparam logic [4:0] O_S  = 5'b00001;  // STOPPED
  localparam logic [4:0] O_SW = 5'b00101;  // STOPPED with WAKE
`ifdef WAKE_DEBOUNCE_EN
  localparam int WLAT = 6;
`else
  localparam int WLAT = 3;
`endif

  // stim = {RESET, OSC_ENA, CLK_ENA, WAKE_N}
  logic [6:0] st_q[$];
  logic [4:0] ex_q[$];
  logic [4:0] exp_q[$];
  logic [4:0] e;
  int total = 0;
  int bad   = 0;

  task automatic add(input logic [6:0] s, input logic [4:0] x, input int n);
    for (int k = 0; k < n; k++) begin
      st_q.push_back(s);
      ex_q.push_back(x);
    end
  endtask

  task automatic test_reset();
    add({3'b111, 4'hF}, O_W, 2);
    add({3'b011, 4'hF}, O_W, 3);
    add({3'b011, 4'hF}, O_R, 2);
    for (int i = 0; st_q.size() > 0; i++) begin
      {RESET, OSC_ENA, CLK_ENA, WAKE_N} = st_q.pop_front();
      exp_q.push_back(ex_q.pop_front());
      @(posedge CLK); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset[%0d] got=%b exp=%b", i, obs, e); end
    end
  endtask

  task automatic test_stop();
    add({3'b001, 4'hF}, O_S, 2);
    for (int i = 0; st_q.size() > 0; i++) begin
      {RESET, OSC_ENA, CLK_ENA, WAKE_N} = st_q.pop_front();
      exp_q.push_back(ex_q.pop_front());
      @(posedge CLK); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL stop[%0d] got=%b exp=%b", i, obs, e); end
    end
  endtask

  task automatic test_wake();
    add({3'b001, 4'hD}, O_S, WLAT - 1);
    add({3'b001, 4'hD}, O_SW, 2);
    add({3'b011, 4'hF}, O_W, 4);
    add({3'b011, 4'hF}, O_R, 1);
    for (int i = 0; st_q.size() > 0; i++) begin
      {RESET, OSC_ENA, CLK_ENA, WAKE_N} = st_q.pop_front();
      exp_q.push_back(ex_q.pop_front());
      @(posedge CLK); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL wake[%0d] got=%b exp=%b", i, obs, e); end
    end
  endtask

  task automatic test_release();
    add({3'b001, 4'hF}, O_S, 1);
    add({3'b001, 4'hE}, O_S, WLAT - 1);
    add({3'b001, 4'hE}, O_SW, 1);
    add({3'b001, 4'hF}, O_SW, 2);
    add({3'b001, 4'hF}, O_S, 1);
    add({3'b011, 4'hF}, O_W, 4);
    add({3'b011, 4'hF}, O_R, 1);
    for (int i = 0; st_q.size() > 0; i++) begin
      {RESET, OSC_ENA, CLK_ENA, WAKE_N} = st_q.pop_front();
      exp_q.push_back(ex_q.pop_front());
      @(posedge CLK); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL release[%0d] got=%b exp=%b", i, obs, e); end
    end
  endtask

  task automatic test_clk_ena();
    add({3'b010, 4'hF}, O_RG, 1);
    add({3'b011, 4'hF}, O_R, 1);
    for (int i = 0; st_q.size() > 0; i++) begin
      {RESET, OSC_ENA, CLK_ENA, WAKE_N} = st_q.pop_front();
      exp_q.push_back(ex_q.pop_front());
      @(posedge CLK); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL clk_ena[%0d] got=%b exp=%b", i, obs, e); end
    end
  endtask

  // Abort at terminal count, then a 1->0->1 toggle early in WARMUP.
  task automatic test_abort();
    add({3'b001, 4'hF}, O_S, 1);
    add({3'b011, 4'hF}, O_W, 4);
    add({3'b001, 4'hF}, O_S, 2);
    add({3'b011, 4'hF}, O_W, 2);
    add({3'b001, 4'hF}, O_S, 1);
    add({3'b011, 4'hF}, O_W, 4);
    add({3'b011, 4'hF}, O_R, 1);
    for (int i = 0; st_q.size() > 0; i++) begin
      {RESET, OSC_ENA, CLK_ENA, WAKE_N} = st_q.pop_front();
      exp_q.push_back(ex_q.pop_front());
      @(posedge CLK); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL abort[%0d] got=%b exp=%b", i, obs, e); end
    end
  endtask

  task automatic test_reset_mid();
    add({3'b001, 4'hF}, O_S, 1);
    add({3'b011, 4'hF}, O_W, 3);
    add({3'b111, 4'hF}, O_W, 1);
    add({3'b011, 4'hF}, O_W, 3);
    add({3'b011, 4'hF}, O_R, 1);
    add({3'b001, 4'hE}, O_S, WLAT - 1);
    add({3'b001, 4'hE}, O_SW, 1);
    add({3'b101, 4'hF}, O_W, 1);
    add({3'b011, 4'hF}, O_W, 3);
    add({3'b011, 4'hF}, O_R, 1);
    for (int i = 0; st_q.size() > 0; i++) begin
      {RESET, OSC_ENA, CLK_ENA, WAKE_N} = st_q.pop_front();
      exp_q.push_back(ex_q.pop_front());
      @(posedge CLK); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset_mid[%0d] got=%b exp=%b", i, obs, e); end
    end
  endtask

  task automatic test_glitch();
    add({3'b001, 4'hF}, O_S, 1);
`ifdef WAKE_DEBOUNCE_EN
    add({3'b001, 4'hE}, O_S, 3);
    add({3'b001, 4'hF}, O_S, 4);
    add({3'b001, 4'hE}, O_S, 5);
    add({3'b001, 4'hE}, O_SW, 2);
`else
    add({3'b001, 4'hE}, O_S, 1);
    add({3'b001, 4'hF}, O_S, 1);
    add({3'b001, 4'hF}, O_SW, 1);
    add({3'b001, 4'hF}, O_S, 2);
`endif
    add({3'b011, 4'hF}, O_W, 4);
    add({3'b011, 4'hF}, O_R, 1);
    for (int i = 0; st_q.size() > 0; i++) begin
      {RESET, OSC_ENA, CLK_ENA, WAKE_N} = st_q.pop_front();
      exp_q.push_back(ex_q.pop_front());
      @(posedge CLK); #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL glitch[%0d] got=%b exp=%b", i, obs, e); end
    end
  endtask

  initial begin
    RESET = 1'b1; OSC_ENA = 1'b1; CLK_ENA = 1'b1; WAKE_N = 4'hF;
    test_reset();
    test_stop();
    test_wake();
    test_release();
    test_clk_ena();
    test_abort();
    test_reset_mid();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
